// File: rtl/fifo_sync_flags_if.sv
// Handshake bundle between a byte producer/consumer and fifo_sync_flags.
// The master side drives strobes and data; the slave side (the FIFO) reports status.
interface fifo_sync_flags_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             flush;
  logic [WIDTH-1:0] write_data;
  logic             write_strobe;
  logic [WIDTH-1:0] read_data;
  logic             read_strobe;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic             almost_empty;
  logic [LW-1:0]    level;
  logic             overflow;
  logic             underflow;
  logic             clear_errors;

  modport master (
    output flush, write_data, write_strobe, read_strobe, clear_errors,
    input  read_data, empty, full, almost_full, almost_empty, level,
           overflow, underflow
  );

  modport slave (
    input  flush, write_data, write_strobe, read_strobe, clear_errors,
    output read_data, empty, full, almost_full, almost_empty, level,
           overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_flags.sv
// Single-clock show-ahead FIFO with registered fill level, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow and flush.
module fifo_sync_flags #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 256,
  parameter int ALMOST_FULL  = 192,
  parameter int ALMOST_EMPTY = 16
) (
  input logic           clk,
  input logic           reset,
  fifo_sync_flags_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF   = LW'(ALMOST_FULL);
  localparam logic [LW-1:0] LVL_AE   = LW'(ALMOST_EMPTY);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [LW-1:0]    r_wr_ptr;
  logic [LW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_overflow;
  logic             r_underflow;

  logic w_empty;
  logic w_full;
  logic w_rd_ok;
  logic w_wr_ok;
  logic w_rd_acc;
  logic w_wr_acc;
  logic w_ovf_set;
  logic w_udf_set;

  // Flags decode only from the registered level, never from the strobes.
  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LVL_FULL);

  // A read frees a slot in the same cycle, so a write at full is still taken.
  assign w_rd_ok  = bus.read_strobe & ~w_empty;
  assign w_wr_ok  = bus.write_strobe & (~w_full | w_rd_ok);
  assign w_rd_acc = w_rd_ok & ~bus.flush;
  assign w_wr_acc = w_wr_ok & ~bus.flush;

  assign w_ovf_set = ~bus.flush & bus.write_strobe & w_full & ~w_rd_ok;
  assign w_udf_set = ~bus.flush & bus.read_strobe & w_empty;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr[AW-1:0]] <= bus.write_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // A fresh error in the same cycle as clear_errors keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_ovf_set | (r_overflow  & ~bus.clear_errors);
      r_underflow <= w_udf_set | (r_underflow & ~bus.clear_errors);
    end
  end

  assign bus.read_data    = r_mem[r_rd_ptr[AW-1:0]];
  assign bus.empty        = w_empty;
  assign bus.full         = w_full;
  assign bus.almost_full  = (r_level >= LVL_AF);
  assign bus.almost_empty = (r_level <= LVL_AE);
  assign bus.level        = r_level;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule
